// File: rtl/iccm_loader_pkg.sv
// Shared types and helpers for the ICCM program loader and its RAM-port mux.
package iccm_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VERIFY,
      ST_CHECK,
      ST_DONE,
      ST_ERR
   } iccm_ld_state_e;

   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   function automatic logic [3:0] laneOneHot(input logic [1:0] lane);
      return 4'b0001 << lane;
   endfunction

endpackage

// File: rtl/iccm_loader_if.sv
// Bundles the byte stream, core fetch, RAM macro and status signals of the loader.
interface iccm_loader_if #(parameter int ADDR_W = 8);

   logic              load_req_i;
   logic [ADDR_W:0]   len_i;
   logic [31:0]       csum_i;
   logic              byte_valid_i;
   logic [7:0]        byte_data_i;
   logic              byte_ready_o;
   logic [31:0]       core_addr_i;
   logic [31:0]       core_instr_o;
   logic              core_rst_o;
   logic              ram_en_o;
   logic [3:0]        ram_we_o;
   logic [ADDR_W-1:0] ram_a_o;
   logic [31:0]       ram_di_o;
   logic [31:0]       ram_do_i;
   logic              done_o;
   logic              err_o;

   modport master (
      input  load_req_i, len_i, csum_i, byte_valid_i, byte_data_i, core_addr_i, ram_do_i,
      output byte_ready_o, core_instr_o, core_rst_o, ram_en_o, ram_we_o, ram_a_o, ram_di_o,
             done_o, err_o
   );

   modport slave (
      output load_req_i, len_i, csum_i, byte_valid_i, byte_data_i, core_addr_i, ram_do_i,
      input  byte_ready_o, core_instr_o, core_rst_o, ram_en_o, ram_we_o, ram_a_o, ram_di_o,
             done_o, err_o
   );

endinterface

// File: rtl/iccm_ram_mux.sv
// Steers the single RAM port either to the core fetch path or to the loader.
module iccm_ram_mux
   import iccm_loader_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic              coreOwns_i,
   input  logic [31:0]       core_addr_i,
   input  logic [31:0]       ram_do_i,
   input  logic              ld_en_i,
   input  logic [3:0]        ld_we_i,
   input  logic [ADDR_W-1:0] ld_a_i,
   input  logic [31:0]       ld_di_i,
   output logic              ram_en_o,
   output logic [3:0]        ram_we_o,
   output logic [ADDR_W-1:0] ram_a_o,
   output logic [31:0]       ram_di_o,
   output logic [31:0]       core_instr_o
);

   // Fetch addresses beyond the RAM simply alias; the dropped bits are intentionally ignored.
   logic unusedAddrBits;
   assign unusedAddrBits = ^{core_addr_i[31:ADDR_W+2], core_addr_i[1:0]};

   always_comb begin
      ram_en_o     = ld_en_i;
      ram_we_o     = ld_we_i;
      ram_a_o      = ld_a_i;
      ram_di_o     = ld_di_i;
      core_instr_o = NOP_INSTR;
      if (coreOwns_i) begin
         ram_en_o     = 1'b1;
         ram_we_o     = 4'b0000;
         ram_a_o      = core_addr_i[ADDR_W+1:2];
         ram_di_o     = 32'h0;
         core_instr_o = ram_do_i;
      end
   end

endmodule

// File: rtl/iccm_loader.sv
// Loads a byte-stream program image into the instruction RAM, verifies its checksum,
// and holds the core in reset until the image is known good.
module iccm_loader
   import iccm_loader_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
   parameter int          RST_HOLD  = 4
) (
   input logic         clk_i,
   input logic         rst_i,
   iccm_loader_if.master bus
);

   localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [3:0]      HOLD_INIT = 4'(RST_HOLD);

   iccm_ld_state_e  state_q, state_d;
   logic [3:0]      hold_q, hold_d;
   logic [ADDR_W:0] len_q, len_d;
   logic [ADDR_W:0] idx_q, idx_d;
   logic [1:0]      lane_q, lane_d;
   logic [31:0]     csum_q, csum_d;
   logic [31:0]     sum_q, sum_d;
   logic            rdVld_q, rdVld_d;
   logic            err_q, err_d;

   logic        lastIdx;
   logic        badLen;
   logic [31:0] sumNext;
   logic        ldEn;
   logic [3:0]  ldWe;
   logic        byteReady;
   logic        donePulse;
   logic        coreRst;

   assign lastIdx = (idx_q == (len_q - ONE));
   assign badLen  = (bus.len_i == '0) || (bus.len_i > DEPTH);
   assign sumNext = sum_q + bus.ram_do_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         hold_q  <= HOLD_INIT;
         len_q   <= '0;
         idx_q   <= '0;
         lane_q  <= 2'd0;
         csum_q  <= 32'h0;
         sum_q   <= 32'h0;
         rdVld_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         lane_q  <= lane_d;
         csum_q  <= csum_d;
         sum_q   <= sum_d;
         rdVld_q <= rdVld_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      len_d     = len_q;
      idx_d     = idx_q;
      lane_d    = lane_q;
      csum_d    = csum_q;
      sum_d     = sum_q;
      rdVld_d   = 1'b0;
      err_d     = err_q;
      ldEn      = 1'b0;
      ldWe      = 4'b0000;
      byteReady = 1'b0;
      donePulse = 1'b0;
      coreRst   = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            coreRst = (hold_q != 4'd0);
            if (hold_q != 4'd0) hold_d = hold_q - 4'd1;
         end
         ST_LOAD: begin
            byteReady = 1'b1;
            if (bus.byte_valid_i) begin
               ldEn   = 1'b1;
               ldWe   = laneOneHot(lane_q);
               lane_d = lane_q + 2'd1;
               if (lane_q == 2'd3) begin
                  if (lastIdx) begin
                     state_d = ST_VERIFY;
                     idx_d   = '0;
                     sum_d   = 32'h0;
                  end else begin
                     idx_d = idx_q + ONE;
                  end
               end
            end
         end
         ST_VERIFY: begin
            ldEn    = 1'b1;
            rdVld_d = 1'b1;
            idx_d   = idx_q + ONE;
            if (rdVld_q) sum_d = sumNext;
            if (lastIdx) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            // The last read word lands this cycle, so compare against the updated sum.
            sum_d = sumNext;
            if (sumNext == csum_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ERR;
               err_d   = 1'b1;
            end
         end
         ST_DONE: begin
            donePulse = 1'b1;
            hold_d    = HOLD_INIT;
            state_d   = ST_IDLE;
         end
         ST_ERR: begin
         end
         default: state_d = ST_IDLE;
      endcase

      // A load request restarts the loader from either IDLE or ERR.
      if (bus.load_req_i && ((state_q == ST_IDLE) || (state_q == ST_ERR))) begin
         len_d   = bus.len_i;
         csum_d  = bus.csum_i;
         idx_d   = '0;
         lane_d  = 2'd0;
         err_d   = badLen;
         state_d = badLen ? ST_ERR : ST_LOAD;
      end
   end

   assign bus.byte_ready_o = byteReady;
   assign bus.core_rst_o   = coreRst;
   assign bus.done_o       = donePulse;
   assign bus.err_o        = err_q;

   iccm_ram_mux #(
      .ADDR_W    (ADDR_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_mux (
      .coreOwns_i   (state_q == ST_IDLE),
      .core_addr_i  (bus.core_addr_i),
      .ram_do_i     (bus.ram_do_i),
      .ld_en_i      (ldEn),
      .ld_we_i      (ldWe),
      .ld_a_i       (idx_q[ADDR_W-1:0]),
      .ld_di_i      ({4{bus.byte_data_i}}),
      .ram_en_o     (bus.ram_en_o),
      .ram_we_o     (bus.ram_we_o),
      .ram_a_o      (bus.ram_a_o),
      .ram_di_o     (bus.ram_di_o),
      .core_instr_o (bus.core_instr_o)
   );

endmodule

// File: tb/tb_iccm_loader.sv
// Directed bench for iccm_loader with a behavioural model of the 256x32 byte-write RAM.
module tb_iccm_loader;
   import iccm_loader_pkg::*;

   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic rst;
   logic clrRam;

   always #5 clk = ~clk;

   iccm_loader_if #(.ADDR_W(ADDR_W)) bus();

   iccm_loader #(
      .ADDR_W    (ADDR_W),
      .NOP_INSTR (32'h0000_0013),
      .RST_HOLD  (4)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Synchronous-read RAM macro model; clrRam seeds a few known words.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (clrRam) begin
         mem[0] <= 32'h0;
         mem[1] <= 32'h0;
         mem[2] <= 32'hDEAD_0002;
         mem[3] <= 32'h0;
      end else if (bus.ram_en_o === 1'b1) begin
         for (int b = 0; b < 4; b++)
            if (bus.ram_we_o[b]) mem[bus.ram_a_o][8*b +: 8] <= bus.ram_di_o[8*b +: 8];
         bus.ram_do_i <= mem[bus.ram_a_o];
      end
   end

   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [7:0]  a;
      logic [3:0]  we;
      logic [31:0] di;
   } wr_t;

   wr_t         writeQ[$];
   logic [31:0] fetchQ[$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic vld, input logic [7:0] data);
      @(posedge clk);
      #1;
      bus.load_req_i   = req;
      bus.byte_valid_i = vld;
      bus.byte_data_i  = data;
      #1;
   endtask

   // Full load: request, stream 4n bytes (optionally with a bubble before each), verify, result.
   task automatic loadImage(input int n, input logic [31:0] csum, input logic [7:0] base,
                            input bit stall);
      logic [31:0] words [0:255];
      logic [31:0] sum;
      logic [7:0]  b;
      wr_t         exp;
      bit          expDone;
      sum = 32'h0;
      for (int w = 0; w < n; w++) words[w] = 32'h0;
      bus.len_i  = 9'(n);
      bus.csum_i = csum;
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 4*n; i++) begin
         if (stall) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput("stall_ram_en", 32'(bus.ram_en_o), 32'd0);
            checkOutput("stall_ready", 32'(bus.byte_ready_o), 32'd1);
         end
         b = base + 8'(i);
         words[i/4][8*(i%4) +: 8] = b;
         writeQ.push_back('{a: 8'(i/4), we: 4'b0001 << (i%4), di: {4{b}}});
         applyStimulus(1'b0, 1'b1, b);
         if (i == 0) checkOutput("err_cleared", 32'(bus.err_o), 32'd0);
         exp = writeQ.pop_front();
         checkOutput("wr_en", 32'(bus.ram_en_o), 32'd1);
         checkOutput("wr_we", 32'(bus.ram_we_o), 32'(exp.we));
         checkOutput("wr_addr", 32'(bus.ram_a_o), 32'(exp.a));
         checkOutput("wr_data", bus.ram_di_o, exp.di);
         checkOutput("load_nop", bus.core_instr_o, 32'h0000_0013);
         checkOutput("load_ready", 32'(bus.byte_ready_o), 32'd1);
      end
      for (int w = 0; w < n; w++) sum = sum + words[w];
      expDone = (sum == csum);
      for (int j = 0; j < n; j++) begin
         applyStimulus(1'b0, 1'b0, 8'h00);
         checkOutput("verify_en", 32'(bus.ram_en_o), 32'd1);
         checkOutput("verify_we", 32'(bus.ram_we_o), 32'd0);
         checkOutput("verify_addr", 32'(bus.ram_a_o), 32'(j));
         checkOutput("verify_ready", 32'(bus.byte_ready_o), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("check_done_low", 32'(bus.done_o), 32'd0);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("result_done", 32'(bus.done_o), 32'(expDone));
      checkOutput("result_err", 32'(bus.err_o), 32'(!expDone));
      checkOutput("result_core_rst", 32'(bus.core_rst_o), 32'd1);
   endtask

   task automatic checkHoldRelease(input string tag);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 1'b0, 8'h00);
         checkOutput({tag, "_held"}, 32'(bus.core_rst_o), 32'd1);
         checkOutput({tag, "_no_done"}, 32'(bus.done_o), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput({tag, "_released"}, 32'(bus.core_rst_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst              = 1'b1;
      clrRam           = 1'b1;
      bus.load_req_i   = 1'b0;
      bus.len_i        = '0;
      bus.csum_i       = 32'h0;
      bus.byte_valid_i = 1'b0;
      bus.byte_data_i  = 8'h00;
      bus.core_addr_i  = 32'h0;

      // Reset values and the post-reset core hold
      applyStimulus(1'b0, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("rst_ready", 32'(bus.byte_ready_o), 32'd0);
      checkOutput("rst_done", 32'(bus.done_o), 32'd0);
      checkOutput("rst_err", 32'(bus.err_o), 32'd0);
      checkOutput("rst_we", 32'(bus.ram_we_o), 32'd0);
      checkOutput("rst_core_rst", 32'(bus.core_rst_o), 32'd1);
      rst    = 1'b0;
      clrRam = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 8'h00);
         checkOutput("por_held", 32'(bus.core_rst_o), 32'd1);
      end
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("por_released", 32'(bus.core_rst_o), 32'd0);

      // Core fetch of byte address 0x8 returns RAM word 2 one cycle later
      bus.core_addr_i = 32'h8;
      #1;
      checkOutput("fetch_addr", 32'(bus.ram_a_o), 32'd2);
      fetchQ.push_back(32'hDEAD_0002);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("fetch_word2", bus.core_instr_o, fetchQ.pop_front());
      bus.core_addr_i = 32'h0;

      $display("[TB] load with wrong checksum");
      loadImage(2, 32'h0000_0A0A, 8'h01, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("err_sticky", 32'(bus.err_o), 32'd1);
      checkOutput("err_core_rst", 32'(bus.core_rst_o), 32'd1);
      checkOutput("err_ram_en", 32'(bus.ram_en_o), 32'd0);
      checkOutput("ram_word0", mem[0], 32'h0403_0201);
      checkOutput("ram_word1", mem[1], 32'h0807_0605);

      $display("[TB] load with matching checksum");
      loadImage(2, 32'h0C0A_0806, 8'h01, 1'b0);
      checkHoldRelease("done_hold");
      fetchQ.push_back(32'h0403_0201);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("fetch_word0", bus.core_instr_o, fetchQ.pop_front());

      $display("[TB] load with stalled byte stream");
      clrRam = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00);
      clrRam = 1'b0;
      loadImage(2, 32'h0C0A_0806, 8'h01, 1'b1);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("stall_word0", mem[0], 32'h0403_0201);
      checkOutput("stall_word1", mem[1], 32'h0807_0605);

      $display("[TB] illegal lengths");
      bus.len_i = 9'd0;
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("len0_err", 32'(bus.err_o), 32'd1);
      checkOutput("len0_we", 32'(bus.ram_we_o), 32'd0);
      checkOutput("len0_en", 32'(bus.ram_en_o), 32'd0);
      checkOutput("len0_ready", 32'(bus.byte_ready_o), 32'd0);
      bus.len_i = 9'd257;
      applyStimulus(1'b1, 1'b0, 8'h00);
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("len257_err", 32'(bus.err_o), 32'd1);
      checkOutput("len257_we", 32'(bus.ram_we_o), 32'd0);
      checkOutput("len257_core_rst", 32'(bus.core_rst_o), 32'd1);
      loadImage(1, 32'h0403_0201, 8'h01, 1'b0);

      $display("[TB] reset in the middle of a load");
      bus.len_i  = 9'd4;
      bus.csum_i = 32'h0;
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h11 + 8'(i));
         checkOutput("partial_we", 32'(bus.ram_we_o), 32'(4'b0001 << i));
      end
      applyStimulus(1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      #1;
      checkOutput("midrst_ready", 32'(bus.byte_ready_o), 32'd0);
      checkOutput("midrst_core_rst", 32'(bus.core_rst_o), 32'd1);
      checkOutput("midrst_done", 32'(bus.done_o), 32'd0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 8'h00);
         checkOutput("midrst_held", 32'(bus.core_rst_o), 32'd1);
         checkOutput("midrst_no_done", 32'(bus.done_o), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 8'h00);
      checkOutput("midrst_released", 32'(bus.core_rst_o), 32'd0);
      checkOutput("partial_word0", mem[0], 32'h0413_1211);
      checkOutput("partial_word1", mem[1], 32'h0807_0605);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/iccm_loader.md
Name: iccm_loader

Overview:
- Owns the single instruction-RAM port (256 x 32 DFFRAM macro, byte write enables, synchronous read) between the core fetch path and a byte-stream program loader.
- On request, holds the core in reset and streams bytes into the RAM, assembling them little-endian into words.
- Reads the image back and checks a 32-bit additive checksum, then releases the core.
- Replaces the testbench-time memory preload for silicon bring-up.

Parameters:
- ADDR_W, 8, RAM word-address width (depth = 2**ADDR_W words).
- NOP_INSTR, 32'h0000_0013, instruction returned to the core while the loader owns the RAM.
- RST_HOLD, 4, cycles core_rst_o stays high after reset release or after a successful load (1..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- load_req_i  in  1  single-cycle load start; sampled only in IDLE
- len_i  in  ADDR_W+1  words to load; valid range 1..2**ADDR_W
- csum_i  in  32  expected mod-2^32 sum of all loaded words
- byte_valid_i  in  1  stream byte valid
- byte_data_i  in  8  stream byte
- byte_ready_o  out  1  stream byte accepted when valid && ready
- core_addr_i  in  32  core fetch byte address
- core_instr_o  out  32  fetch data to core
- core_rst_o  out  1  active-high reset to core
- ram_en_o  out  1  RAM enable
- ram_we_o  out  4  RAM byte write enables
- ram_a_o  out  ADDR_W  RAM word address
- ram_di_o  out  32  RAM write data
- ram_do_i  in  32  RAM read data, valid one cycle after the read address
- done_o  out  1  one-cycle pulse on checksum match
- err_o  out  1  sticky error; cleared by the next accepted load_req_i or by rst_i

Behaviour:
- Reset values:
  - state = IDLE; core_rst_o = 1; hold counter = RST_HOLD.
  - byte_ready_o = 0, done_o = 0, err_o = 0, ram_we_o = 0.
- States: IDLE, LOAD, VERIFY, CHECK, DONE, ERR.
- IDLE:
  - RAM port is given to the core: ram_en_o = 1, ram_we_o = 0, ram_a_o = core_addr_i[ADDR_W+1:2], core_instr_o = ram_do_i.
  - core_rst_o = 1 while the hold counter is nonzero; the counter decrements each cycle.
  - On load_req_i: latch len and csum, clear err_o, set word index = 0 and byte lane = 0.
    - If len_i == 0 or len_i > 2**ADDR_W, go to ERR.
    - Otherwise go to LOAD.
- LOAD:
  - core_rst_o = 1; core_instr_o = NOP_INSTR; byte_ready_o = 1.
  - Each accepted byte is written immediately to lane `lane` of word `index`:
    - ram_we_o = one-hot(lane); ram_di_o = {4{byte_data_i}}; ram_a_o = index; ram_en_o = 1.
    - ram_en_o = 0 on cycles with no accepted byte.
  - lane increments and wraps 3 -> 0. On wrap, index increments.
  - After lane 3 of word len-1 is accepted, go to VERIFY with index = 0 and sum = 0.
  - load_req_i is ignored in LOAD.
- VERIFY:
  - byte_ready_o = 0; one read issued per cycle: ram_en_o = 1, ram_we_o = 0, ram_a_o = index.
  - A one-cycle-delayed valid flag adds ram_do_i into sum (mod 2^32).
  - After index len-1 is issued, go to CHECK.
  - Total VERIFY duration is len cycles.
- CHECK (1 cycle):
  - Adds the final read word.
  - The comparison uses the updated sum: match goes to DONE, mismatch goes to ERR.
- DONE:
  - done_o = 1 for this cycle only; reload hold counter = RST_HOLD; go to IDLE.
  - The core comes out of reset RST_HOLD cycles later.
- ERR:
  - err_o = 1 (sticky); core_rst_o = 1; RAM idle; byte_ready_o = 0.
  - Only load_req_i (treated exactly as in IDLE) or rst_i leaves ERR.
- Latency for a full load of N words: 4N accepted byte cycles + N verify cycles + 1 check cycle + 1 done cycle.
- rst_i mid-operation: return to IDLE in the next cycle. The partial image stays in RAM and is not erased. The core is held RST_HOLD cycles.
- Core fetch addresses above the RAM range alias by truncation. The block does not check them.

Decomposition:
- Package iccm_loader_pkg holds:
  - state enum (iccm_ld_state_e).
  - NOP_INSTR default.
  - lane-to-one-hot function.
- One sub-module, iccm_ram_mux: the combinational RAM-port mux between the core fetch port and the loader port, selected by the owner bit.

Test Plan:
- After reset, with no load: core_rst_o stays 1 for exactly 4 cycles after rst_i falls, then 0. core_addr_i = 0x8 reads RAM word 2 on the following cycle.
- load_req_i, len = 2, csum = 0x0000_0A0A, bytes 01 02 03 04 05 06 07 08 (ready always high) -> word0 = 0x04030201 and word1 = 0x08070605 (sum 0x0C0A0806 != csum) -> err_o = 1, core_rst_o stays 1.
- Same stream with csum = 0x0C0A0806 -> done_o pulses once, 8+2+1+1 cycles after the first byte, when no stall is inserted. core_rst_o falls 4 cycles later. The core fetches 0x04030201 at address 0.
- Same stream with byte_valid_i toggled off every other cycle -> identical RAM contents. ram_en_o is low on idle cycles.
- len_i = 0 and, separately, len_i = 257 -> ERR next cycle, no RAM writes. A subsequent valid load_req_i clears err_o and proceeds.
- rst_i after 3 bytes of a 4-word load -> IDLE next cycle. byte_ready_o = 0. core_rst_o is held 4 cycles then released. done_o never pulses.
